// File: rtl/sha1_rounds_engine_if.sv
// sha1_rounds_engine_if -- bus between the hash controller and the SHA-1
// rounds engine.
//   rounds_en   controller -> engine  level enable (start in IDLE, advance in RUN)
//   h_in[159:0] controller -> engine  chaining value, H0 in [159:128] .. H4 in [31:0]
//   w_t[31:0]   controller -> engine  schedule word W[round_idx], same cycle
//   round_idx   engine -> controller  current round t (0..79), 0 outside RUN
//   busy        engine -> controller  high in RUN and ADD
//   rounds_done engine -> controller  one-cycle completion pulse
//   hh[159:0]   engine -> controller  block digest, same word order as h_in
interface sha1_rounds_engine_if;
   logic         rounds_en;
   logic [159:0] h_in;
   logic [31:0]  w_t;
   logic [6:0]   round_idx;
   logic         busy;
   logic         rounds_done;
   logic [159:0] hh;

   modport master (
      output rounds_en, h_in, w_t,
      input  round_idx, busy, rounds_done, hh
   );

   modport slave (
      input  rounds_en, h_in, w_t,
      output round_idx, busy, rounds_done, hh
   );
endinterface

// File: rtl/sha1_rounds_engine.sv
// sha1_rounds_engine -- the 80-round SHA-1 compression loop for one
// 512-bit block, one round per enabled clock, followed by the final
// per-word addition of the chaining value.
//   clk         rising-edge system clock
//   rst_rounds  asynchronous active-high reset; clears state and outputs
//   bus         sha1_rounds_engine_if.slave (rounds_en, h_in, w_t in;
//               round_idx, busy, rounds_done, hh out)
// Sequence: IDLE -(rounds_en)-> RUN (80 rounds, stalls while rounds_en=0)
//           -> ADD -> DONE (rounds_done pulse) -> WAIT (until rounds_en=0).
module sha1_rounds_engine (
   input  logic                  clk,
   input  logic                  rst_rounds,
   sha1_rounds_engine_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      ADD,
      DONE,
      WAIT
   } state_t;

   localparam logic [6:0] LAST_ROUND = 7'd79;

   state_t       state;
   state_t       state_nxt;

   logic [31:0]  a, b, c, d, e;
   logic [6:0]   t;
   logic [159:0] hh_q;

   logic [31:0]  f_t;
   logic [31:0]  k_t;
   logic [31:0]  temp;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_rounds) begin
      if (rst_rounds) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next state and state-decoded outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt       = state;
      bus.busy        = 1'b0;
      bus.rounds_done = 1'b0;
      bus.round_idx   = '0;
      case (state)
         IDLE: begin
            if (bus.rounds_en) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            bus.busy      = 1'b1;
            bus.round_idx = t;
            if (bus.rounds_en && (t == LAST_ROUND)) begin
               state_nxt = ADD;
            end
         end
         ADD: begin
            bus.busy  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.rounds_done = 1'b1;
            state_nxt       = WAIT;
         end
         WAIT: begin
            // A held enable must drop before another block can start.
            if (!bus.rounds_en) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Round function and constant for the current round
   // ---------------------------------------------------------------
   always_comb begin
      f_t = '0;
      k_t = '0;
      if (t < 7'd20) begin
         f_t = (b & c) | (~b & d);
         k_t = 32'h5A827999;
      end else if (t < 7'd40) begin
         f_t = b ^ c ^ d;
         k_t = 32'h6ED9EBA1;
      end else if (t < 7'd60) begin
         f_t = (b & c) | (b & d) | (c & d);
         k_t = 32'h8F1BBCDC;
      end else begin
         f_t = b ^ c ^ d;
         k_t = 32'hCA62C1D6;
      end
      temp = {a[26:0], a[31:27]} + f_t + e + k_t + bus.w_t;
   end

   // ---------------------------------------------------------------
   // Working variables, round counter and digest register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_rounds) begin
      if (rst_rounds) begin
         a    <= '0;
         b    <= '0;
         c    <= '0;
         d    <= '0;
         e    <= '0;
         t    <= '0;
         hh_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.rounds_en) begin
                  a <= bus.h_in[159:128];
                  b <= bus.h_in[127:96];
                  c <= bus.h_in[95:64];
                  d <= bus.h_in[63:32];
                  e <= bus.h_in[31:0];
                  t <= '0;
               end
            end
            RUN: begin
               if (bus.rounds_en) begin
                  e <= d;
                  d <= c;
                  c <= {b[1:0], b[31:2]};
                  b <= a;
                  a <= temp;
                  // t parks at 79 on the last round; IDLE reloads it.
                  if (t != LAST_ROUND) begin
                     t <= t + 7'd1;
                  end
               end
            end
            ADD: begin
               hh_q <= {bus.h_in[159:128] + a,
                        bus.h_in[127:96]  + b,
                        bus.h_in[95:64]   + c,
                        bus.h_in[63:32]   + d,
                        bus.h_in[31:0]    + e};
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.hh = hh_q;

endmodule

// File: tb/tb_sha1_rounds_engine.sv
// tb_sha1_rounds_engine -- directed and randomized check of
// sha1_rounds_engine against a plain SHA-1 compression model.
module tb_sha1_rounds_engine;

   logic clk;
   logic rst_rounds;

   sha1_rounds_engine_if bus ();

   sha1_rounds_engine dut (
      .clk        (clk),
      .rst_rounds (rst_rounds),
      .bus        (bus)
   );

   // Schedule words presented combinationally for the current round.
   logic [31:0] w_arr [0:79];
   assign bus.w_t = w_arr[bus.round_idx];

   int unsigned pass_cnt;
   int unsigned fail_cnt;
   int unsigned total_cnt;

   localparam logic [159:0] IV        = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
   localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Standard SHA-1 compression of one block.
   function automatic logic [159:0] sha1_ref(input logic [159:0] iv, input logic [511:0] blk);
      logic [31:0] w [80];
      logic [31:0] va, vb, vc, vd, ve, f, k, tmp;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
      {va, vb, vc, vd, ve} = iv;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (vb & vc) | (~vb & vd);            k = 32'h5A827999; end
         else if (i < 40) begin f = vb ^ vc ^ vd;                      k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (vb & vc) | (vb & vd) | (vc & vd); k = 32'h8F1BBCDC; end
         else             begin f = vb ^ vc ^ vd;                      k = 32'hCA62C1D6; end
         tmp = rotl(va, 5) + f + ve + k + w[i];
         ve = vd; vd = vc; vc = rotl(vb, 30); vb = va; va = tmp;
      end
      return {iv[159:128] + va, iv[127:96] + vb, iv[95:64] + vc, iv[63:32] + vd, iv[31:0] + ve};
   endfunction

   function automatic void load_sched(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) w_arr[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 80; i++) w_arr[i] = rotl(w_arr[i-3] ^ w_arr[i-8] ^ w_arr[i-14] ^ w_arr[i-16], 1);
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one block from IDLE. Optional 3-cycle stalls when round stall_a /
   // stall_b is current (-1 = none). After rounds_done, rounds_en stays high
   // for 'hold' more cycles, then drops and the engine returns to IDLE.
   task automatic run_block(input string tag, input logic [159:0] iv, input logic [511:0] blk,
                            input logic [159:0] exp, input int stall_a, input int stall_b,
                            input int hold);
      int cyc, exec, busy_cnt, idx_err, done_cyc, n_stall, extra_done, extra_busy;
      bit sa_done, sb_done;
      cyc = 0; exec = 0; busy_cnt = 0; idx_err = 0; done_cyc = -1;
      extra_done = 0; extra_busy = 0; sa_done = 0; sb_done = 0;
      n_stall = ((stall_a >= 0) ? 1 : 0) + ((stall_b >= 0) ? 1 : 0);
      bus.h_in = iv;
      load_sched(blk);
      bus.rounds_en = 1'b1;
      step();  // start edge
      while (cyc < 300) begin
         if (bus.busy) busy_cnt++;
         if (bus.round_idx !== 7'((exec < 80) ? exec : 0)) idx_err++;
         if (bus.rounds_done) begin
            done_cyc = cyc;
            break;
         end
         if ((exec == stall_a && !sa_done) || (exec == stall_b && !sb_done)) begin
            if (exec == stall_a) sa_done = 1'b1; else sb_done = 1'b1;
            bus.rounds_en = 1'b0;
            repeat (3) begin
               step();
               cyc++;
               if (bus.busy) busy_cnt++;
               if (bus.round_idx !== 7'(exec)) idx_err++;
            end
            bus.rounds_en = 1'b1;
         end
         step();
         cyc++;
         exec++;
      end
      chk({tag, " digest"}, bus.hh, exp);
      chk({tag, " done_cycle"}, 160'(done_cyc), 160'(81 + 3*n_stall));
      chk({tag, " busy_cycles"}, 160'(busy_cnt), 160'(81 + 3*n_stall));
      chk({tag, " round_idx_seq_errors"}, 160'(idx_err), 160'(0));
      repeat (hold) begin
         step();
         if (bus.rounds_done) extra_done++;
         if (bus.busy) extra_busy++;
      end
      chk({tag, " extra_done_in_wait"}, 160'(extra_done), 160'(0));
      chk({tag, " busy_in_wait"}, 160'(extra_busy), 160'(0));
      bus.rounds_en = 1'b0;
      step();
      chk({tag, " hh_held"}, bus.hh, exp);
   endtask

   initial begin
      int g;
      int cnt_done, cnt_busy;
      logic [159:0] riv;
      logic [511:0] rblk;
      pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
      for (int i = 0; i < 80; i++) w_arr[i] = '0;
      bus.rounds_en = 1'b0;
      bus.h_in = '0;
      rst_rounds = 1'b0;

      // Reset takes effect before any clock edge.
      #2 rst_rounds = 1'b1;
      #1;
      chk("reset round_idx", 160'(bus.round_idx), 160'(0));
      chk("reset busy", 160'(bus.busy), 160'(0));
      chk("reset rounds_done", 160'(bus.rounds_done), 160'(0));
      chk("reset hh", bus.hh, '0);
      step();
      step();
      rst_rounds = 1'b0;

      // Known-answer vectors.
      run_block("abc", IV, ABC_BLK, ABC_DIG, -1, -1, 1);
      run_block("empty", IV, EMPTY_BLK, EMPTY_DIG, -1, -1, 1);
      run_block("abc_stall", IV, ABC_BLK, ABC_DIG, 10, 79, 1);

      // Enable held after completion: no restart until it toggles.
      run_block("abc_hold", IV, ABC_BLK, ABC_DIG, -1, -1, 10);
      run_block("empty_after_toggle", IV, EMPTY_BLK, EMPTY_DIG, -1, -1, 1);

      // Reset in the middle of RUN.
      bus.h_in = IV;
      load_sched(ABC_BLK);
      bus.rounds_en = 1'b1;
      step();
      g = 0;
      while (bus.round_idx != 7'd40 && g < 100) begin
         step();
         g++;
      end
      chk("mid_rst reached_t40", 160'(bus.round_idx), 160'(40));
      rst_rounds = 1'b1;
      #1;
      chk("mid_rst round_idx", 160'(bus.round_idx), 160'(0));
      chk("mid_rst busy", 160'(bus.busy), 160'(0));
      chk("mid_rst rounds_done", 160'(bus.rounds_done), 160'(0));
      chk("mid_rst hh", bus.hh, '0);
      bus.rounds_en = 1'b0;
      step();
      step();
      rst_rounds = 1'b0;
      cnt_done = 0; cnt_busy = 0;
      repeat (100) begin
         step();
         if (bus.rounds_done) cnt_done++;
         if (bus.busy) cnt_busy++;
      end
      chk("post_rst no_done", 160'(cnt_done), 160'(0));
      chk("post_rst no_busy", 160'(cnt_busy), 160'(0));

      // Release of reset with rounds_en already high starts on the next edge.
      rst_rounds = 1'b1;
      bus.rounds_en = 1'b1;
      step();
      chk("rst_with_en busy", 160'(bus.busy), 160'(0));
      rst_rounds = 1'b0;
      run_block("abc_after_rst", IV, ABC_BLK, ABC_DIG, -1, -1, 1);

      // Random chaining values and blocks against the model.
      for (int n = 0; n < 4; n++) begin
         riv = {$urandom, $urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
         run_block($sformatf("rand%0d", n), riv, rblk, sha1_ref(riv, rblk),
                   (n % 2 == 1) ? int'($urandom_range(0, 79)) : -1, -1, 1 + n);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sha1_rounds_engine.md
SHA1_ROUNDS_ENGINE -- requirements
Module: sha1_rounds_engine

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed by SHA-1.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_rounds  input  1  reset, asynchronous, active-high; clears all state and outputs.
REQ-004 rounds_en  input  1  level enable from the hash controller; starts a block in IDLE and advances one round per cycle in RUN.
REQ-005 h_in  input  160  chaining value; H0 in [159:128] through H4 in [31:0]; stable from start until rounds_done.
REQ-006 w_t  input  32  schedule word W[round_idx], supplied combinationally by the extension unit in the same cycle.
REQ-007 round_idx  output  7  current round number t (0..79); 0 when not in RUN.
REQ-008 busy  output  1  high in RUN and ADD.
REQ-009 rounds_done  output  1  single-cycle completion pulse to the hash controller.
REQ-010 hh  output  160  block digest in the same word order as h_in; holds its value until the next ADD or reset.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN, ADD, DONE and WAIT.
REQ-012 IDLE: when rounds_en=1 at an edge, load a..e from h_in (a=H0 ... e=H4), set t=0, and go to RUN.
REQ-013 RUN with rounds_en=1 at an edge: temp = rotl5(a)+f_t(b,c,d)+e+K_t+w_t mod 2^32; e<=d; d<=c; c<=rotl30(b); b<=a; a<=temp; t<=t+1.
REQ-014 f/K: t 0-19 Ch=(b&c)|(~b&d), 5A827999; t 20-39 b^c^d, 6ED9EBA1; t 40-59 Maj, 8F1BBCDC; t 60-79 b^c^d, CA62C1D6.
REQ-015 RUN with rounds_en=0: hold a..e and t (stall); round_idx SHALL stay constant.
REQ-016 After the edge that executes t=79, go to ADD; t SHALL NOT wrap to 0 inside RUN.
REQ-017 ADD (one cycle): hh[i] <= h_in[i] + reg[i] per 32-bit word, mod 2^32 with no carry between words; go to DONE.
REQ-018 DONE (one cycle): rounds_done=1; go to WAIT.
REQ-019 WAIT: stay while rounds_en=1; go to IDLE when rounds_en=0, so a held enable cannot restart the engine.
REQ-020 Unstalled latency: start edge E0, rounds E1-E80, hh valid after E81, rounds_done high during the cycle after E81.
REQ-021 rounds_done SHALL be exactly one cycle wide per block.

Reset
REQ-022 While rst_rounds=1: state=IDLE, a..e=0, t=0, round_idx=0, busy=0, rounds_done=0, hh=0, with no clock needed.
REQ-023 rst_rounds asserted in any state, including mid-RUN, SHALL abort the block; no rounds_done SHALL follow.
REQ-024 After rst_rounds is released, the engine SHALL need a fresh rounds_en in IDLE to start.
REQ-025 If rst_rounds releases while rounds_en=1, the next edge SHALL start a block from IDLE.

Verification
REQ-026 IV 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0 with W from the padded "abc" block, rounds_en held high -> hh = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, rounds_done 81 cycles after start.
REQ-027 Same IV with the padded empty message (W0=80000000, other W=0) -> hh = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
REQ-028 Check the "abc" vector with rounds_en dropped for 3 cycles at t=10 and t=79 -> same digest; rounds_done 6 cycles later; round_idx frozen during each stall.
REQ-029 Pulse rst_rounds at t=40 -> all outputs 0 immediately; no rounds_done; a fresh start then gives the correct digest.
REQ-030 Hold rounds_en high for 10 cycles after rounds_done -> engine stays in WAIT; busy=0; no second rounds_done until rounds_en toggles low then high.
REQ-031 Monitor round_idx over an unstalled block -> sequence 0,1,...,79, then 0; busy high for exactly 81 cycles.
